// File: rtl/snoop_responder_if.sv
// snoop_responder_if
// Bundles every handshake/bus signal of the L2 snoop responder: the snoop request and
// result channel from the system bus, the tag lookup and MESI update ports toward the L2
// tag array, and the line writeback channel.
//
// Modports:
//   slave  - the snoop responder: takes snp_*, lk_hit/lk_way/lk_mesi and wb_ready;
//            drives snp_ready, res_*, lk_valid/lk_index/lk_tag, upd_* and wb_valid/wb_addr.
//   master - the bus / tag-array side: the mirror image of slave.
interface snoop_responder_if #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned OFFSET_W = 6,
   parameter int unsigned INDEX_W  = 14,
   parameter int unsigned WAY_W    = 3
);
   localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

   // snoop request / result
   logic               snp_valid;
   logic               snp_ready;
   logic [1:0]         snp_op;
   logic [ADDR_W-1:0]  snp_addr;
   logic               res_valid;
   logic [1:0]         res;

   // tag lookup
   logic               lk_valid;
   logic [INDEX_W-1:0] lk_index;
   logic [TAG_W-1:0]   lk_tag;
   logic               lk_hit;
   logic [WAY_W-1:0]   lk_way;
   logic [1:0]         lk_mesi;

   // MESI write-back into the tag array
   logic               upd_valid;
   logic [INDEX_W-1:0] upd_index;
   logic [WAY_W-1:0]   upd_way;
   logic [1:0]         upd_mesi;

   // line writeback
   logic               wb_valid;
   logic               wb_ready;
   logic [ADDR_W-1:0]  wb_addr;

   modport slave (
      input  snp_valid, snp_op, snp_addr,
      output snp_ready, res_valid, res,
      output lk_valid, lk_index, lk_tag,
      input  lk_hit, lk_way, lk_mesi,
      output upd_valid, upd_index, upd_way, upd_mesi,
      output wb_valid, wb_addr,
      input  wb_ready
   );

   modport master (
      output snp_valid, snp_op, snp_addr,
      input  snp_ready, res_valid, res,
      input  lk_valid, lk_index, lk_tag,
      output lk_hit, lk_way, lk_mesi,
      input  upd_valid, upd_index, upd_way, upd_mesi,
      input  wb_valid, wb_addr,
      output wb_ready
   );
endinterface

// File: rtl/snoop_responder.sv
// snoop_responder
// Bus-side MESI snoop responder for the L2. Accepts one snooped transaction at a time,
// looks the line up in the L2 tag store, writes back a Modified line when the snoop
// demands it, writes the new MESI state into the tag store and reports HIT/HITM/NOHIT.
//
// Ports:
//   clk, rst  - clock; synchronous active-high reset
//   bus       - snoop_responder_if.slave: snoop request/result, tag lookup, MESI update
//               and writeback channels
//   cnt_hit, cnt_hitm, cnt_nohit (only with SNOOP_STATS_EN defined) - saturating 16-bit
//               counts of HIT, HITM and NOHIT results since reset
//
// Build option: define SNOOP_STATS_EN to add the result counters.
//
// Sequence per snoop (A = accept cycle): LOOKUP at A+1, EVAL at A+2, optional WB until the
// writeback handshake, UPDATE, RESP, then back to IDLE. All outputs are registered.
module snoop_responder #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned OFFSET_W = 6,
   parameter int unsigned INDEX_W  = 14,
   parameter int unsigned WAY_W    = 3
) (
   input  logic             clk,
   input  logic             rst,
   snoop_responder_if.slave bus
`ifdef SNOOP_STATS_EN
   ,
   output logic [15:0]      cnt_hit,
   output logic [15:0]      cnt_hitm,
   output logic [15:0]      cnt_nohit
`endif
);
   localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_RFO   = 2'd2;
   localparam logic [1:0] OP_INVAL = 2'd3;

   localparam logic [1:0] MESI_I = 2'd0;
   localparam logic [1:0] MESI_S = 2'd1;
   localparam logic [1:0] MESI_E = 2'd2;
   localparam logic [1:0] MESI_M = 2'd3;

   localparam logic [1:0] RES_HIT   = 2'd0;
   localparam logic [1:0] RES_HITM  = 2'd1;
   localparam logic [1:0] RES_NOHIT = 2'd2;

   typedef enum logic [2:0] {
      st_idle,
      st_lookup,
      st_eval,
      st_wb,
      st_update,
      st_resp
   } state_t;

   state_t              state;

   // latched snoop and evaluation results
   logic [1:0]          op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [WAY_W-1:0]    way_q;
   logic [1:0]          nxt_q;
   logic [1:0]          res_q;
   logic                chg_q;

   // registered outputs
   logic                snp_ready_q;
   logic                res_valid_q;
   logic [1:0]          res_out_q;
   logic                lk_valid_q;
   logic [INDEX_W-1:0]  lk_index_q;
   logic [TAG_W-1:0]    lk_tag_q;
   logic                upd_valid_q;
   logic [INDEX_W-1:0]  upd_index_q;
   logic [WAY_W-1:0]    upd_way_q;
   logic [1:0]          upd_mesi_q;
   logic                wb_valid_q;
   logic [ADDR_W-1:0]   wb_addr_q;

   // protocol evaluation of the lookup result, meaningful only in st_eval
   logic [1:0]          cur_mesi;
   logic [1:0]          eval_mesi;
   logic [1:0]          eval_res;
   logic                eval_wb;

   always_comb begin
      // lk_mesi is not trusted on a miss
      cur_mesi  = bus.lk_hit ? bus.lk_mesi : MESI_I;
      eval_mesi = cur_mesi;
      eval_res  = RES_NOHIT;
      eval_wb   = 1'b0;
      unique case (op_q)
         OP_READ: begin
            unique case (cur_mesi)
               MESI_M: begin
                  eval_mesi = MESI_S;
                  eval_res  = RES_HITM;
                  eval_wb   = 1'b1;
               end
               MESI_E, MESI_S: begin
                  eval_mesi = MESI_S;
                  eval_res  = RES_HIT;
               end
               default: ;
            endcase
         end
         OP_RFO: begin
            unique case (cur_mesi)
               MESI_M: begin
                  eval_mesi = MESI_I;
                  eval_res  = RES_HITM;
                  eval_wb   = 1'b1;
               end
               MESI_E, MESI_S: begin
                  eval_mesi = MESI_I;
                  eval_res  = RES_HIT;
               end
               default: ;
            endcase
         end
         // an invalidating snoop drops even a Modified line without writing it back
         OP_INVAL: eval_mesi = MESI_I;
         OP_WRITE: ;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= st_idle;
         op_q        <= '0;
         addr_q      <= '0;
         way_q       <= '0;
         nxt_q       <= '0;
         res_q       <= '0;
         chg_q       <= 1'b0;
         snp_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
         res_out_q   <= '0;
         lk_valid_q  <= 1'b0;
         lk_index_q  <= '0;
         lk_tag_q    <= '0;
         upd_valid_q <= 1'b0;
         upd_index_q <= '0;
         upd_way_q   <= '0;
         upd_mesi_q  <= '0;
         wb_valid_q  <= 1'b0;
         wb_addr_q   <= '0;
      end else begin
         // single-cycle strobes
         lk_valid_q  <= 1'b0;
         upd_valid_q <= 1'b0;
         res_valid_q <= 1'b0;
         unique case (state)
            st_idle: begin
               if (bus.snp_valid && snp_ready_q) begin
                  op_q        <= bus.snp_op;
                  addr_q      <= bus.snp_addr;
                  snp_ready_q <= 1'b0;
                  lk_valid_q  <= 1'b1;
                  lk_index_q  <= bus.snp_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
                  lk_tag_q    <= bus.snp_addr[ADDR_W-1:INDEX_W+OFFSET_W];
                  state       <= st_lookup;
               end
            end
            st_lookup: begin
               // lookup result arrives during st_eval
               state <= st_eval;
            end
            st_eval: begin
               way_q <= bus.lk_way;
               nxt_q <= eval_mesi;
               res_q <= eval_res;
               chg_q <= (eval_mesi != cur_mesi);
               if (eval_wb) begin
                  wb_valid_q <= 1'b1;
                  wb_addr_q  <= {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                  state      <= st_wb;
               end else begin
                  upd_valid_q <= (eval_mesi != cur_mesi);
                  upd_index_q <= addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
                  upd_way_q   <= bus.lk_way;
                  upd_mesi_q  <= eval_mesi;
                  state       <= st_update;
               end
            end
            st_wb: begin
               if (bus.wb_ready) begin
                  wb_valid_q  <= 1'b0;
                  upd_valid_q <= chg_q;
                  upd_index_q <= addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
                  upd_way_q   <= way_q;
                  upd_mesi_q  <= nxt_q;
                  state       <= st_update;
               end
            end
            st_update: begin
               res_valid_q <= 1'b1;
               res_out_q   <= res_q;
               state       <= st_resp;
            end
            st_resp: begin
               snp_ready_q <= 1'b1;
               state       <= st_idle;
            end
            default: begin
               snp_ready_q <= 1'b1;
               state       <= st_idle;
            end
         endcase
      end
   end

   assign bus.snp_ready = snp_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res       = res_out_q;
   assign bus.lk_valid  = lk_valid_q;
   assign bus.lk_index  = lk_index_q;
   assign bus.lk_tag    = lk_tag_q;
   assign bus.upd_valid = upd_valid_q;
   assign bus.upd_index = upd_index_q;
   assign bus.upd_way   = upd_way_q;
   assign bus.upd_mesi  = upd_mesi_q;
   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_addr   = wb_addr_q;

`ifdef SNOOP_STATS_EN
   // counts follow the result strobe as it appears on the bus
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_hit   <= '0;
         cnt_hitm  <= '0;
         cnt_nohit <= '0;
      end else if (res_valid_q) begin
         case (res_out_q)
            RES_HIT:   if (cnt_hit   != 16'hFFFF) cnt_hit   <= cnt_hit + 16'd1;
            RES_HITM:  if (cnt_hitm  != 16'hFFFF) cnt_hitm  <= cnt_hitm + 16'd1;
            RES_NOHIT: if (cnt_nohit != 16'hFFFF) cnt_nohit <= cnt_nohit + 16'd1;
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder
// Self-checking bench for snoop_responder: directed vector table, hand-written sequences
// for back-to-back snoops and reset during writeback, and randomized snoops checked
// against a table-based MESI snoop model. Counter checks are built with SNOOP_STATS_EN.
module tb_snoop_responder;
   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_RFO   = 2'd2;
   localparam logic [1:0] OP_INVAL = 2'd3;
   localparam logic [1:0] ST_I = 2'd0;
   localparam logic [1:0] ST_S = 2'd1;
   localparam logic [1:0] ST_E = 2'd2;
   localparam logic [1:0] ST_M = 2'd3;
   localparam logic [1:0] R_HIT   = 2'd0;
   localparam logic [1:0] R_HITM  = 2'd1;
   localparam logic [1:0] R_NOHIT = 2'd2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   snoop_responder_if bus ();

`ifdef SNOOP_STATS_EN
   logic [15:0] cnt_hit, cnt_hitm, cnt_nohit;
`endif

   snoop_responder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef SNOOP_STATS_EN
      ,
      .cnt_hit   (cnt_hit),
      .cnt_hitm  (cnt_hitm),
      .cnt_nohit (cnt_nohit)
`endif
   );

   // tag store: answers in the cycle after lk_valid, garbage at all other times
   logic       lk_pend = 1'b0;
   logic       rsp_hit = 1'b0;
   logic [2:0] rsp_way = '0;
   logic [1:0] rsp_mesi = '0;
   logic       junk_hit = 1'b0;
   logic [2:0] junk_way = '0;
   logic [1:0] junk_mesi = '0;

   always @(posedge clk) lk_pend <= bus.lk_valid;
   always @(negedge clk) begin
      junk_hit  <= 1'($urandom);
      junk_way  <= 3'($urandom);
      junk_mesi <= 2'($urandom);
   end
   assign bus.lk_hit  = lk_pend ? rsp_hit  : junk_hit;
   assign bus.lk_way  = lk_pend ? rsp_way  : junk_way;
   assign bus.lk_mesi = lk_pend ? rsp_mesi : junk_mesi;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // reference model: per (op, effective state) the next state, result and writeback need
   logic [1:0] m_next [4][4];
   logic [1:0] m_res  [4][4];
   bit         m_wb   [4][4];

   task automatic init_model();
      for (int o = 0; o < 4; o++)
         for (int s = 0; s < 4; s++) begin
            m_next[o][s] = 2'(s);
            m_res[o][s]  = R_NOHIT;
            m_wb[o][s]   = 1'b0;
         end
      m_next[OP_READ][ST_M] = ST_S; m_res[OP_READ][ST_M] = R_HITM; m_wb[OP_READ][ST_M] = 1'b1;
      m_next[OP_READ][ST_E] = ST_S; m_res[OP_READ][ST_E] = R_HIT;
      m_res[OP_READ][ST_S]  = R_HIT;
      m_next[OP_RFO][ST_M]  = ST_I; m_res[OP_RFO][ST_M]  = R_HITM; m_wb[OP_RFO][ST_M]  = 1'b1;
      m_next[OP_RFO][ST_E]  = ST_I; m_res[OP_RFO][ST_E]  = R_HIT;
      m_next[OP_RFO][ST_S]  = ST_I; m_res[OP_RFO][ST_S]  = R_HIT;
      for (int s = 0; s < 4; s++) m_next[OP_INVAL][s] = ST_I;
   endtask

   typedef struct {
      bit          accepted;
      int          lk_cnt;
      int          lk_cyc;
      logic [13:0] lk_index;
      logic [11:0] lk_tag;
      int          wb_cnt;
      logic [31:0] wb_addr;
      bit          wb_unstable;
      int          upd_cnt;
      int          upd_cyc;
      logic [13:0] upd_index;
      logic [2:0]  upd_way;
      logic [1:0]  upd_mesi;
      int          res_cnt;
      int          res_cyc;
      logic [1:0]  res;
      int          rdy_cyc;
   } obs_t;

   // Drive one snoop and record what the DUT does, cycle 0 being the accept cycle.
   // wb_wait = number of wb_valid cycles seen before wb_ready is raised.
   task automatic run_txn(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                          input logic [2:0] way, input logic [1:0] mesi, input int wb_wait,
                          output obs_t o);
      o = '{default: 0};
      o.rdy_cyc = -1;
      rsp_hit = hit;
      rsp_way = way;
      rsp_mesi = mesi;
      bus.wb_ready = 1'b0;
      @(negedge clk);
      o.accepted = bus.snp_ready;
      bus.snp_valid = 1'b1;
      bus.snp_op = op;
      bus.snp_addr = addr;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus.snp_valid = 1'b0;
            bus.snp_op = 2'($urandom);
            bus.snp_addr = $urandom;
         end
         if (bus.lk_valid) begin
            o.lk_cnt++;
            o.lk_cyc = c;
            o.lk_index = bus.lk_index;
            o.lk_tag = bus.lk_tag;
         end
         if (bus.wb_valid) begin
            if (o.wb_cnt == 0) o.wb_addr = bus.wb_addr;
            else if (bus.wb_addr != o.wb_addr) o.wb_unstable = 1'b1;
            o.wb_cnt++;
            bus.wb_ready = (o.wb_cnt > wb_wait);
         end else begin
            bus.wb_ready = 1'($urandom);
         end
         if (bus.upd_valid) begin
            o.upd_cnt++;
            o.upd_cyc = c;
            o.upd_index = bus.upd_index;
            o.upd_way = bus.upd_way;
            o.upd_mesi = bus.upd_mesi;
         end
         if (bus.res_valid) begin
            o.res_cnt++;
            o.res_cyc = c;
            o.res = bus.res;
         end
         if (bus.snp_ready) begin
            o.rdy_cyc = c;
            break;
         end
      end
      bus.wb_ready = 1'b0;
   endtask

   task automatic check_txn(input string t, input logic [1:0] op, input logic [31:0] addr,
                            input logic hit, input logic [2:0] way, input logic [1:0] mesi,
                            input int wb_wait, input obs_t o);
      logic [1:0] cur, nxt;
      bit         wb;
      int         base;
      cur = hit ? mesi : ST_I;
      nxt = m_next[op][cur];
      wb = m_wb[op][cur];
      base = wb ? 4 + wb_wait : 3;  // cycle of the update slot
      check({t, ".accept"}, o.accepted, 1);
      check({t, ".lk_cnt"}, o.lk_cnt, 1);
      check({t, ".lk_cyc"}, o.lk_cyc, 1);
      check({t, ".lk_index"}, o.lk_index, (addr >> 6) & 32'h3FFF);
      check({t, ".lk_tag"}, o.lk_tag, addr >> 20);
      check({t, ".wb_cnt"}, o.wb_cnt, wb ? wb_wait + 1 : 0);
      if (wb) begin
         check({t, ".wb_addr"}, o.wb_addr, addr & ~32'h3F);
         check({t, ".wb_unstable"}, o.wb_unstable, 0);
      end
      check({t, ".upd_cnt"}, o.upd_cnt, (nxt != cur) ? 1 : 0);
      if (nxt != cur) begin
         check({t, ".upd_cyc"}, o.upd_cyc, base);
         check({t, ".upd_index"}, o.upd_index, (addr >> 6) & 32'h3FFF);
         check({t, ".upd_way"}, o.upd_way, way);
         check({t, ".upd_mesi"}, o.upd_mesi, nxt);
      end
      check({t, ".res_cnt"}, o.res_cnt, 1);
      check({t, ".res_cyc"}, o.res_cyc, base + 1);
      check({t, ".res"}, o.res, m_res[op][cur]);
      check({t, ".rdy_cyc"}, o.rdy_cyc, base + 2);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic        hit;
      logic [2:0]  way;
      logic [1:0]  mesi;
      int          wb_wait;
      logic [1:0]  exp_res;
      bit          exp_upd;
      logic [1:0]  exp_mesi;
      bit          exp_wb;
      int          exp_res_cyc;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t       o;
      bit         seen;
      int         bad;
      logic [11:0] acc_mask, lk_mask, res_mask;
      logic [1:0] rop, rmesi;
      logic [31:0] raddr;
      logic       rhit;
      logic [2:0] rway;
      int         rwait;

      init_model();
      // READ M with wb_ready on the 3rd wb_valid cycle: W=A+5, upd A+6, res A+7, ready A+8
      vecs[0] = '{OP_READ,  32'h0040_1000, 1'b1, 3'd5, ST_M, 2, R_HITM,  1'b1, ST_S, 1'b1, 7};
      vecs[1] = '{OP_READ,  32'h1234_5678, 1'b1, 3'd2, ST_E, 0, R_HIT,   1'b1, ST_S, 1'b0, 4};
      vecs[2] = '{OP_RFO,   32'h0000_2040, 1'b1, 3'd3, ST_S, 0, R_HIT,   1'b1, ST_I, 1'b0, 4};
      vecs[3] = '{OP_RFO,   32'hDEAD_BEC0, 1'b0, 3'd7, ST_M, 0, R_NOHIT, 1'b0, ST_I, 1'b0, 4};
      vecs[4] = '{OP_INVAL, 32'h8000_0000, 1'b1, 3'd1, ST_S, 0, R_NOHIT, 1'b1, ST_I, 1'b0, 4};
      vecs[5] = '{OP_WRITE, 32'h0F0F_0F00, 1'b1, 3'd4, ST_E, 0, R_NOHIT, 1'b0, ST_I, 1'b0, 4};
      vecs[6] = '{OP_INVAL, 32'h0000_0040, 1'b1, 3'd6, ST_M, 0, R_NOHIT, 1'b1, ST_I, 1'b0, 4};
      vecs[7] = '{OP_READ,  32'hFFFF_FFC0, 1'b1, 3'd0, ST_I, 0, R_NOHIT, 1'b0, ST_I, 1'b0, 4};
      vecs[8] = '{OP_RFO,   32'h7654_3210, 1'b1, 3'd2, ST_M, 0, R_HITM,  1'b1, ST_I, 1'b1, 5};
      vecs[9] = '{OP_READ,  32'h0000_1000, 1'b1, 3'd1, ST_S, 0, R_HIT,   1'b0, ST_I, 1'b0, 4};

      bus.snp_valid = 1'b0;
      bus.snp_op = '0;
      bus.snp_addr = '0;
      bus.wb_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset.snp_ready", bus.snp_ready, 1);
      check("reset.lk_valid", bus.lk_valid, 0);
      check("reset.res_valid", bus.res_valid, 0);
      check("reset.res", bus.res, 0);
      check("reset.upd_valid", bus.upd_valid, 0);
      check("reset.upd_mesi", bus.upd_mesi, 0);
      check("reset.wb_valid", bus.wb_valid, 0);
      check("reset.wb_addr", bus.wb_addr, 0);
      check("reset.lk_index", bus.lk_index, 0);
      rst = 1'b0;

      // directed vector table
      foreach (vecs[i]) begin
         run_txn(vecs[i].op, vecs[i].addr, vecs[i].hit, vecs[i].way, vecs[i].mesi,
                 vecs[i].wb_wait, o);
         check($sformatf("vec%0d.res", i), o.res, vecs[i].exp_res);
         check($sformatf("vec%0d.upd", i), o.upd_cnt, vecs[i].exp_upd ? 1 : 0);
         if (vecs[i].exp_upd) check($sformatf("vec%0d.upd_mesi", i), o.upd_mesi, vecs[i].exp_mesi);
         check($sformatf("vec%0d.wb", i), (o.wb_cnt > 0) ? 1 : 0, vecs[i].exp_wb ? 1 : 0);
         check($sformatf("vec%0d.res_cyc", i), o.res_cyc, vecs[i].exp_res_cyc);
         check($sformatf("vec%0d.rdy_cyc", i), o.rdy_cyc, vecs[i].exp_res_cyc + 1);
         check_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].hit, vecs[i].way,
                   vecs[i].mesi, vecs[i].wb_wait, o);
      end

      // snp_valid held high: accepts at 0, 5, 10; lookups never overlap
      rsp_hit = 1'b1;
      rsp_way = 3'd4;
      rsp_mesi = ST_E;
      acc_mask = '0;
      lk_mask = '0;
      res_mask = '0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) begin
            bus.snp_valid = 1'b1;
            bus.snp_op = OP_READ;
            bus.snp_addr = 32'hCAFE_0080;
         end
         if (bus.snp_valid && bus.snp_ready) acc_mask[c] = 1'b1;
         if (bus.lk_valid) lk_mask[c] = 1'b1;
         if (bus.res_valid) res_mask[c] = 1'b1;
      end
      @(negedge clk);
      bus.snp_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.snp_ready) begin
            seen = 1'b1;
            break;
         end
      end
      check("b2b.accept_mask", acc_mask, 12'h421);
      check("b2b.lk_mask", lk_mask, 12'h842);
      check("b2b.res_mask", res_mask, 12'h210);
      check("b2b.drained", seen, 1);

      // reset while stalled in writeback
      rsp_hit = 1'b1;
      rsp_way = 3'd3;
      rsp_mesi = ST_M;
      bus.wb_ready = 1'b0;
      @(negedge clk);
      bus.snp_valid = 1'b1;
      bus.snp_op = OP_READ;
      bus.snp_addr = 32'h0055_AA40;
      @(negedge clk);
      bus.snp_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.wb_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("rstwb.reached_wb", seen, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rstwb.snp_ready", bus.snp_ready, 1);
      check("rstwb.wb_valid", bus.wb_valid, 0);
      check("rstwb.wb_addr", bus.wb_addr, 0);
      check("rstwb.upd_valid", bus.upd_valid, 0);
      check("rstwb.res_valid", bus.res_valid, 0);
      check("rstwb.lk_valid", bus.lk_valid, 0);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         bus.wb_ready = 1'($urandom);
         if (bus.res_valid || bus.upd_valid || bus.wb_valid || !bus.snp_ready) bad++;
      end
      bus.wb_ready = 1'b0;
      check("rstwb.quiet_after", bad, 0);

`ifdef SNOOP_STATS_EN
      // counters were cleared by the reset above; the dropped snoop is not counted
      run_txn(OP_READ,  32'h0000_0100, 1'b1, 3'd0, ST_E, 0, o);
      check_txn("st0", OP_READ,  32'h0000_0100, 1'b1, 3'd0, ST_E, 0, o);
      run_txn(OP_READ,  32'h0000_0200, 1'b1, 3'd1, ST_S, 0, o);
      check_txn("st1", OP_READ,  32'h0000_0200, 1'b1, 3'd1, ST_S, 0, o);
      run_txn(OP_RFO,   32'h0000_0300, 1'b1, 3'd2, ST_S, 0, o);
      check_txn("st2", OP_RFO,   32'h0000_0300, 1'b1, 3'd2, ST_S, 0, o);
      run_txn(OP_READ,  32'h0000_0400, 1'b1, 3'd3, ST_M, 1, o);
      check_txn("st3", OP_READ,  32'h0000_0400, 1'b1, 3'd3, ST_M, 1, o);
      run_txn(OP_WRITE, 32'h0000_0500, 1'b1, 3'd4, ST_E, 0, o);
      check_txn("st4", OP_WRITE, 32'h0000_0500, 1'b1, 3'd4, ST_E, 0, o);
      run_txn(OP_READ,  32'h0000_0600, 1'b0, 3'd5, ST_M, 0, o);
      check_txn("st5", OP_READ,  32'h0000_0600, 1'b0, 3'd5, ST_M, 0, o);
      check("stats.cnt_hit", cnt_hit, 3);
      check("stats.cnt_hitm", cnt_hitm, 1);
      check("stats.cnt_nohit", cnt_nohit, 2);
`endif

      // randomized snoops against the model
      for (int i = 0; i < 200; i++) begin
         rop = 2'($urandom);
         raddr = $urandom;
         rhit = 1'($urandom);
         rway = 3'($urandom);
         rmesi = 2'($urandom);
         rwait = int'($urandom_range(0, 3));
         run_txn(rop, raddr, rhit, rway, rmesi, rwait, o);
         check_txn($sformatf("rnd%0d", i), rop, raddr, rhit, rway, rmesi, rwait, o);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
